mlp_layer_seq: RTL
==================

// Module: mlp_layer_seq
// PURPOSE
//  Self-sequencing fully-connected MLP layer: N_NEURONS parallel MACs share one streamed input.
//  Internal FSM, valid/ready input handshake, fixed-point rescale, optional ReLU, signed saturation.
//  Sits between an input-vector source (DMA/previous layer) and the next layer's input stream.
// PARAMETERS
//  N_INPUTS   4   inputs per vector (>=2)
//  N_NEURONS  8   neurons / parallel MACs (>=1)
//  IN_WIDTH   16  signed input width
//  WGT_WIDTH  16  signed weight width
//  MAC_WIDTH  40  signed accumulator width; must be >= IN_WIDTH+WGT_WIDTH+clog2(N_INPUTS)
//  OUT_WIDTH  16  signed output width per neuron
//  FRAC_BITS  8   weight fraction bits; accumulator arithmetic-shifted right by this before saturation
// PORTS
//  clk           in   1                       clock, all state on posedge
//  rst           in   1                       asynchronous, active-high reset
//  wr_en         in   1                       weight write strobe (honoured in IDLE only)
//  wr_row        in   clog2(N_NEURONS)        neuron index of the weight write
//  wr_col        in   clog2(N_INPUTS)         input index of the weight write
//  wr_weight     in   WGT_WIDTH               weight data
//  start         in   1                       begin a vector: clears accumulators, latches relu_en
//  relu_en       in   1                       ReLU select, sampled with start
//  in_valid      in   1                       in_data valid
//  in_ready      out  1                       layer accepts in_data
//  in_data       in   IN_WIDTH                signed input element, index order 0..N_INPUTS-1
//  busy          out  1                       high in any state other than IDLE
//  out_valid     out  1                       one-cycle pulse: outputs_flat updated
//  outputs_flat  out  N_NEURONS*OUT_WIDTH     neuron n at [n*OUT_WIDTH +: OUT_WIDTH]
// BEHAVIOUR
//  Reset: state=IDLE; index counter, accumulators, outputs_flat, out_valid, in_ready, busy all 0.
//   Weight (and bias) RAM is not reset; contents are retained across rst.
//  FSM: IDLE -start-> ACCUM -last accept-> DRAIN -> ACT -> IDLE.
//  IDLE: in_ready=0; wr_en writes weight[wr_row][wr_col]; start clears accumulators, idx=0.
//   start and wr_en asserted in the same cycle: both take effect.
//  ACCUM: in_ready=1; accept on in_valid&in_ready.
//   Stage 1 (accept edge): register in_data and weight[n][idx] for every n; idx++.
//   Stage 2 (next edge): acc[n] += in*w, full-precision signed product, wraps at MAC_WIDTH.
//   Accept with idx==N_INPUTS-1 -> DRAIN. Gaps in in_valid stall without loss.
//  DRAIN: in_ready=0; last product accumulates.
//  ACT: per neuron r = (acc>>>FRAC_BITS) [+bias]. If relu latched and r<0, r=0.
//   r saturated to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] and loaded into outputs_flat.
//   out_valid=1 for exactly one cycle after this edge.
//  Latency: outputs valid 2 edges after the edge accepting the last input; throughput 1 input/cycle.
//  outputs_flat holds its value until the next ACT.
//  start, wr_en while busy are ignored (no effect on state, weights or accumulators).
//  rst mid-vector: immediate abort to IDLE, no out_valid; partial results discarded.
//  Shift rounds toward -inf. Accumulator overflow wraps, so size MAC_WIDTH per the rule above.
// CONFIGURATION
//  MLP_LAYER_BIAS_EN defined: extra ports bias_wr_en(1), bias_wr_row(clog2(N_NEURONS)),
//   bias_wr_data(OUT_WIDTH, signed); per-neuron bias RAM, writes honoured in IDLE only.
//   Bias is sign-extended and added after the shift, before ReLU/saturation, in MAC_WIDTH+1 bits.
//  Undefined: no bias ports or RAM; r = acc>>>FRAC_BITS.
// TESTING
//  1 Identity: FRAC_BITS=8, all weights 256, inputs 1,2,3,4, relu=0 -> every neuron 10; out_valid single pulse.
//  2 ReLU: neuron0 weights -256, inputs 1..4: relu=1 -> 0x0000; relu=0 -> 0xFFF6 (-10).
//  3 Saturation: weights and inputs 0x7FFF -> 0x7FFF; weights 0x8001, inputs 0x7FFF, relu=0 -> 0x8000.
//  4 Backpressure: test 1 with random in_valid gaps; start and wr_en pulsed while busy -> result 10, weights unchanged.
//  5 Reset: rst after 2 accepts -> busy=0, outputs_flat=0, no out_valid; rerun test 1 -> 10; weights retained.
//  6 MLP_LAYER_BIAS_EN: bias[n]=5 on test 1 -> 15; bias=-20, relu=1 -> 0.

Source files
------------

// File: rtl/mlp_layer_if.sv
// ============================================================================
// Module   : mlp_layer_if
// Brief    : Weight-write, vector-stream and result bus of mlp_layer_seq.
// Config   : MLP_LAYER_BIAS_EN adds the bias-write signals.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mlp_layer_if #(
  parameter int N_INPUTS  = 4,
  parameter int N_NEURONS = 8,
  parameter int IN_WIDTH  = 16,
  parameter int WGT_WIDTH = 16,
  parameter int OUT_WIDTH = 16
);
  localparam int c_row_w = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  localparam int c_col_w = $clog2(N_INPUTS);

  logic                           wr_en;
  logic [c_row_w-1:0]             wr_row;
  logic [c_col_w-1:0]             wr_col;
  logic [WGT_WIDTH-1:0]           wr_weight;
  logic                           start;
  logic                           relu_en;
  logic                           in_valid;
  logic                           in_ready;
  logic [IN_WIDTH-1:0]            in_data;
  logic                           busy;
  logic                           out_valid;
  logic [N_NEURONS*OUT_WIDTH-1:0] outputs_flat;
`ifdef MLP_LAYER_BIAS_EN
  logic                           bias_wr_en;
  logic [c_row_w-1:0]             bias_wr_row;
  logic [OUT_WIDTH-1:0]           bias_wr_data;
`endif

  modport master (
`ifdef MLP_LAYER_BIAS_EN
    output bias_wr_en, bias_wr_row, bias_wr_data,
`endif
    output wr_en, wr_row, wr_col, wr_weight, start, relu_en, in_valid, in_data,
    input  in_ready, busy, out_valid, outputs_flat
  );

  modport slave (
`ifdef MLP_LAYER_BIAS_EN
    input  bias_wr_en, bias_wr_row, bias_wr_data,
`endif
    input  wr_en, wr_row, wr_col, wr_weight, start, relu_en, in_valid, in_data,
    output in_ready, busy, out_valid, outputs_flat
  );
endinterface

`default_nettype wire

// File: rtl/mlp_layer_seq.sv
// ============================================================================
// Module   : mlp_layer_seq
// Brief    : Self-sequencing fully-connected layer, one streamed input shared
//            by N_NEURONS MACs, with rescale, optional ReLU and saturation.
// Config   : MLP_LAYER_BIAS_EN enables the per-neuron bias RAM and ports.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mlp_layer_seq #(
  parameter int N_INPUTS  = 4,
  parameter int N_NEURONS = 8,
  parameter int IN_WIDTH  = 16,
  parameter int WGT_WIDTH = 16,
  parameter int MAC_WIDTH = 40,
  parameter int OUT_WIDTH = 16,
  parameter int FRAC_BITS = 8
) (
  input wire logic   clk,
  input wire logic   rst,
  mlp_layer_if.slave bus
);
  localparam int c_col_w = $clog2(N_INPUTS);
  localparam int c_sum_w = MAC_WIDTH + 1;
  localparam logic signed [c_sum_w-1:0]   c_sum_max = c_sum_w'((longint'(1) << (OUT_WIDTH-1)) - 1);
  localparam logic signed [c_sum_w-1:0]   c_sum_min = c_sum_w'(-(longint'(1) << (OUT_WIDTH-1)));
  localparam logic signed [OUT_WIDTH-1:0] c_res_max = {1'b0, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [OUT_WIDTH-1:0] c_res_min = {1'b1, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DRAIN = 2'd2,
    S_ACT   = 2'd3
  } state_t;

  state_t                         r_state;
  logic [c_col_w-1:0]             r_idx;
  logic                           r_relu;
  logic                           r_mac_en;
  logic                           r_in_ready;
  logic                           r_busy;
  logic                           r_out_valid;
  logic signed [IN_WIDTH-1:0]     r_x;
  logic signed [WGT_WIDTH-1:0]    r_w    [N_NEURONS];
  logic signed [MAC_WIDTH-1:0]    r_acc  [N_NEURONS];
  logic [N_NEURONS*OUT_WIDTH-1:0] r_out;
  logic signed [WGT_WIDTH-1:0]    r_wmem [N_NEURONS][N_INPUTS];

  logic signed [MAC_WIDTH-1:0]    w_prod [N_NEURONS];
  logic signed [OUT_WIDTH-1:0]    w_res  [N_NEURONS];
  logic                           w_idle;
  logic                           w_accept;

  assign w_idle   = (r_state == S_IDLE);
  assign w_accept = bus.in_valid && r_in_ready;

  // Coefficient storage has no reset so a layer keeps its weights across rst.
  always_ff @(posedge clk) begin
    if (w_idle && bus.wr_en) begin
      r_wmem[bus.wr_row][bus.wr_col] <= bus.wr_weight;
    end
  end

`ifdef MLP_LAYER_BIAS_EN
  logic signed [OUT_WIDTH-1:0] r_bias [N_NEURONS];

  always_ff @(posedge clk) begin
    if (w_idle && bus.bias_wr_en) begin
      r_bias[bus.bias_wr_row] <= bus.bias_wr_data;
    end
  end
`endif

  for (genvar n = 0; n < N_NEURONS; n++) begin : g_neuron
    logic signed [MAC_WIDTH-1:0] w_shift;
    logic signed [c_sum_w-1:0]   w_sum;
    logic signed [c_sum_w-1:0]   w_relu;

    assign w_prod[n] = MAC_WIDTH'(r_x) * MAC_WIDTH'(r_w[n]);
    assign w_shift   = r_acc[n] >>> FRAC_BITS;
`ifdef MLP_LAYER_BIAS_EN
    assign w_sum     = c_sum_w'(w_shift) + c_sum_w'(r_bias[n]);
`else
    assign w_sum     = c_sum_w'(w_shift);
`endif
    assign w_relu    = (r_relu && w_sum[c_sum_w-1]) ? '0 : w_sum;
    assign w_res[n]  = (w_relu > c_sum_max) ? c_res_max :
                       (w_relu < c_sum_min) ? c_res_min :
                       w_relu[OUT_WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_relu      <= 1'b0;
      r_mac_en    <= 1'b0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_x         <= '0;
      r_out       <= '0;
      for (int n = 0; n < N_NEURONS; n++) begin
        r_w[n]   <= '0;
        r_acc[n] <= '0;
      end
    end else begin
      r_out_valid <= 1'b0;
      r_mac_en    <= 1'b0;
      // Second pipeline stage: the product registered on the previous accept.
      if (r_mac_en) begin
        for (int n = 0; n < N_NEURONS; n++) begin
          r_acc[n] <= r_acc[n] + w_prod[n];
        end
      end
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state    <= S_ACCUM;
            r_idx      <= '0;
            r_relu     <= bus.relu_en;
            r_in_ready <= 1'b1;
            r_busy     <= 1'b1;
            for (int n = 0; n < N_NEURONS; n++) begin
              r_acc[n] <= '0;
            end
          end
        end
        S_ACCUM: begin
          if (w_accept) begin
            r_x      <= bus.in_data;
            r_mac_en <= 1'b1;
            r_idx    <= r_idx + c_col_w'(1);
            for (int n = 0; n < N_NEURONS; n++) begin
              r_w[n] <= r_wmem[n][r_idx];
            end
            if (r_idx == c_col_w'(N_INPUTS - 1)) begin
              r_state    <= S_DRAIN;
              r_in_ready <= 1'b0;
            end
          end
        end
        S_DRAIN: begin
          r_state <= S_ACT;
        end
        S_ACT: begin
          for (int n = 0; n < N_NEURONS; n++) begin
            r_out[n*OUT_WIDTH +: OUT_WIDTH] <= w_res[n];
          end
          r_out_valid <= 1'b1;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready     = r_in_ready;
  assign bus.busy         = r_busy;
  assign bus.out_valid    = r_out_valid;
  assign bus.outputs_flat = r_out;

endmodule

`default_nettype wire
